// File: rtl/trap_sequencer.sv
// trap_sequencer: owns the machine-mode CSR write port, sequencing trap entry and mret
// against MEM-stage CSR instructions. Define TRAP_MTVAL_EN to include the mtval save step.
module trap_sequencer #(
    parameter logic [11:0] MTVEC_ADDR   = 12'h305,
    parameter logic [11:0] MEPC_ADDR    = 12'h341,
    parameter logic [11:0] MCAUSE_ADDR  = 12'h342,
    parameter logic [11:0] MTVAL_ADDR   = 12'h343,
    parameter logic [11:0] MSTATUS_ADDR = 12'h300
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        csr_rw_in,
    input  logic [11:0] csr_rw_addr_in,
    input  logic [31:0] csr_wdata_in,
    input  logic [1:0]  csr_wsc_in,
    output logic        csr_rw_ready,
    input  logic        illegal_inst,
    input  logic        ecall_m,
    input  logic        l_access_fault,
    input  logic        s_access_fault,
    input  logic        interrupt,
    input  logic        mret,
    input  logic [31:0] epc_cur,
    input  logic [31:0] tval_in,
    input  logic [31:0] mstatus,
    input  logic [31:0] csr_rdata,
    output logic        csr_w,
    output logic [11:0] csr_waddr,
    output logic [31:0] csr_wdata,
    output logic [1:0]  csr_wsc,
    output logic [11:0] csr_raddr,
    output logic        stall,
    output logic        flush,
    output logic        RegWrite_cancel,
    output logic        redirect_mux,
    output logic [31:0] PC_redirect
);
    typedef enum logic [3:0] {
        IDLE, SAVE_EPC, SAVE_CAUSE, SAVE_TVAL, UPD_STATUS,
        READ_VEC, REDIRECT, MRET_STATUS, MRET_EPC
    } state_t;

    localparam logic [1:0]  WSC_WRITE      = 2'b01;
    localparam logic [31:0] CAUSE_ILLEGAL  = 32'd2;
    localparam logic [31:0] CAUSE_ECALL_M  = 32'd11;
    localparam logic [31:0] CAUSE_LOAD_AF  = 32'd5;
    localparam logic [31:0] CAUSE_STORE_AF = 32'd7;
    localparam logic [31:0] CAUSE_IRQ      = 32'h8000_000B;

    state_t      r_state;
    logic [31:0] r_cause, r_epc, r_tval, r_target;

    logic        w_exc, w_trap, w_mret_take;
    logic [31:0] w_cause, w_tval, w_st_trap, w_st_mret;

    assign w_exc       = illegal_inst | ecall_m | l_access_fault | s_access_fault;
    assign w_trap      = w_exc | (interrupt & mstatus[3]);
    assign w_mret_take = mret & ~w_exc;

    // Cause/tval selection by fixed priority
    always_comb begin
        w_cause = CAUSE_IRQ;
        w_tval  = '0;
        if (illegal_inst) begin
            w_cause = CAUSE_ILLEGAL;
            w_tval  = tval_in;
        end else if (ecall_m) begin
            w_cause = CAUSE_ECALL_M;
        end else if (l_access_fault) begin
            w_cause = CAUSE_LOAD_AF;
            w_tval  = tval_in;
        end else if (s_access_fault) begin
            w_cause = CAUSE_STORE_AF;
            w_tval  = tval_in;
        end
    end

    // mstatus images for trap entry (MPIE<-MIE, MIE<-0, MPP<-M) and mret (MIE<-MPIE, MPIE<-1)
    always_comb begin
        w_st_trap        = mstatus;
        w_st_trap[7]     = mstatus[3];
        w_st_trap[3]     = 1'b0;
        w_st_trap[12:11] = 2'b11;
        w_st_mret        = mstatus;
        w_st_mret[3]     = mstatus[7];
        w_st_mret[7]     = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cause  <= '0;
            r_epc    <= '0;
            r_tval   <= '0;
            r_target <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_trap) begin
                        r_state <= SAVE_EPC;
                        r_cause <= w_cause;
                        r_epc   <= epc_cur;
                        r_tval  <= w_tval;
                    end else if (w_mret_take) begin
                        r_state <= MRET_STATUS;
                    end
                end
                SAVE_EPC:    r_state <= SAVE_CAUSE;
`ifdef TRAP_MTVAL_EN
                SAVE_CAUSE:  r_state <= SAVE_TVAL;
`else
                SAVE_CAUSE:  r_state <= UPD_STATUS;
`endif
                SAVE_TVAL:   r_state <= UPD_STATUS;
                UPD_STATUS:  r_state <= READ_VEC;
                READ_VEC: begin
                    r_target <= {csr_rdata[31:2], 2'b00};
                    r_state  <= REDIRECT;
                end
                MRET_STATUS: r_state <= MRET_EPC;
                MRET_EPC: begin
                    r_target <= csr_rdata;
                    r_state  <= REDIRECT;
                end
                REDIRECT:    r_state <= IDLE;
                default:     r_state <= IDLE;
            endcase
        end
    end

    // Port decode; reset forces every output low regardless of event inputs
    always_comb begin
        csr_rw_ready    = 1'b0;
        csr_w           = 1'b0;
        csr_waddr       = '0;
        csr_wdata       = '0;
        csr_wsc         = '0;
        csr_raddr       = '0;
        stall           = 1'b0;
        flush           = 1'b0;
        RegWrite_cancel = 1'b0;
        redirect_mux    = 1'b0;
        PC_redirect     = '0;
        if (!rst) begin
            stall = (r_state != IDLE);
            case (r_state)
                IDLE: begin
                    if (w_trap) begin
                        flush           = 1'b1;
                        RegWrite_cancel = 1'b1;
                    end else if (w_mret_take) begin
                        flush = 1'b1;
                    end else if (csr_rw_in) begin
                        csr_rw_ready = 1'b1;
                        csr_w        = 1'b1;
                        csr_waddr    = csr_rw_addr_in;
                        csr_wdata    = csr_wdata_in;
                        csr_wsc      = csr_wsc_in;
                        csr_raddr    = csr_rw_addr_in;
                    end
                end
                SAVE_EPC: begin
                    csr_w = 1'b1; csr_waddr = MEPC_ADDR; csr_wdata = r_epc; csr_wsc = WSC_WRITE;
                end
                SAVE_CAUSE: begin
                    csr_w = 1'b1; csr_waddr = MCAUSE_ADDR; csr_wdata = r_cause; csr_wsc = WSC_WRITE;
                end
                SAVE_TVAL: begin
                    csr_w = 1'b1; csr_waddr = MTVAL_ADDR; csr_wdata = r_tval; csr_wsc = WSC_WRITE;
                end
                UPD_STATUS: begin
                    csr_w = 1'b1; csr_waddr = MSTATUS_ADDR; csr_wdata = w_st_trap; csr_wsc = WSC_WRITE;
                end
                READ_VEC:  csr_raddr = MTVEC_ADDR;
                MRET_STATUS: begin
                    csr_w = 1'b1; csr_waddr = MSTATUS_ADDR; csr_wdata = w_st_mret; csr_wsc = WSC_WRITE;
                end
                MRET_EPC:  csr_raddr = MEPC_ADDR;
                REDIRECT: begin
                    redirect_mux = 1'b1;
                    PC_redirect  = r_target;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_trap_sequencer.sv
// Self-checking bench for trap_sequencer: a behavioural CSR file plus write/redirect
// scoreboards, a table of single-cycle CSR-instruction vectors and hand-built trap sequences.
module tb_trap_sequencer;
    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MTVAL    = 12'h343;
`ifdef TRAP_MTVAL_EN
    localparam int TRAP_LAT = 6;
`else
    localparam int TRAP_LAT = 5;
`endif

    typedef struct {
        logic        rw;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [1:0]  wsc;
        logic        intr;
        logic        exp_ready;
        logic        exp_flush;
    } vec_t;

    typedef struct {
        logic [11:0] addr;
        logic [31:0] data;
        logic [1:0]  wsc;
        int          cyc;
    } wr_t;

    typedef struct {
        logic [31:0] pc;
        int          cyc;
    } rd_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        csr_rw_in = 1'b0;
    logic [11:0] csr_rw_addr_in = '0;
    logic [31:0] csr_wdata_in = '0;
    logic [1:0]  csr_wsc_in = '0;
    logic        illegal_inst = 1'b0, ecall_m = 1'b0, l_access_fault = 1'b0;
    logic        s_access_fault = 1'b0, interrupt = 1'b0, mret = 1'b0;
    logic [31:0] epc_cur = '0, tval_in = '0;
    logic [31:0] csr_rdata;
    logic        csr_rw_ready, csr_w, stall, flush, RegWrite_cancel, redirect_mux;
    logic [11:0] csr_waddr, csr_raddr;
    logic [31:0] csr_wdata, PC_redirect;
    logic [1:0]  csr_wsc;

    logic [31:0] m_mtvec = 32'h200, m_mepc = '0, m_mcause = '0, m_mtval = '0;
    logic [31:0] m_mstatus = 32'h8, m_mscratch = '0;

    int  n_cmp = 0, n_fail = 0, cyc = 0;
    wr_t wq[$];
    rd_t rq[$];
    wr_t mon_w;
    rd_t mon_r;
    vec_t vecs[8];

    trap_sequencer dut (
        .clk(clk), .rst(rst),
        .csr_rw_in(csr_rw_in), .csr_rw_addr_in(csr_rw_addr_in),
        .csr_wdata_in(csr_wdata_in), .csr_wsc_in(csr_wsc_in),
        .csr_rw_ready(csr_rw_ready),
        .illegal_inst(illegal_inst), .ecall_m(ecall_m),
        .l_access_fault(l_access_fault), .s_access_fault(s_access_fault),
        .interrupt(interrupt), .mret(mret),
        .epc_cur(epc_cur), .tval_in(tval_in), .mstatus(m_mstatus),
        .csr_rdata(csr_rdata),
        .csr_w(csr_w), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata), .csr_wsc(csr_wsc),
        .csr_raddr(csr_raddr),
        .stall(stall), .flush(flush), .RegWrite_cancel(RegWrite_cancel),
        .redirect_mux(redirect_mux), .PC_redirect(PC_redirect)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] wsc_apply(input logic [31:0] old, input logic [31:0] d,
                                               input logic [1:0] wsc);
        case (wsc)
            2'b01:   return d;
            2'b10:   return old | d;
            2'b11:   return old & ~d;
            default: return old;
        endcase
    endfunction

    // Behavioural CSR file: combinational read, write committed at the rising edge
    always_comb begin
        case (csr_raddr)
            A_MTVEC:    csr_rdata = m_mtvec;
            A_MEPC:     csr_rdata = m_mepc;
            A_MCAUSE:   csr_rdata = m_mcause;
            A_MTVAL:    csr_rdata = m_mtval;
            A_MSTATUS:  csr_rdata = m_mstatus;
            A_MSCRATCH: csr_rdata = m_mscratch;
            default:    csr_rdata = '0;
        endcase
    end

    always @(posedge clk) begin
        if (!rst && csr_w) begin
            case (csr_waddr)
                A_MTVEC:    m_mtvec    <= wsc_apply(m_mtvec, csr_wdata, csr_wsc);
                A_MEPC:     m_mepc     <= wsc_apply(m_mepc, csr_wdata, csr_wsc);
                A_MCAUSE:   m_mcause   <= wsc_apply(m_mcause, csr_wdata, csr_wsc);
                A_MTVAL:    m_mtval    <= wsc_apply(m_mtval, csr_wdata, csr_wsc);
                A_MSTATUS:  m_mstatus  <= wsc_apply(m_mstatus, csr_wdata, csr_wsc);
                A_MSCRATCH: m_mscratch <= wsc_apply(m_mscratch, csr_wdata, csr_wsc);
                default: ;
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Write-port and redirect scoreboards
    always @(negedge clk) begin
        if (csr_w) begin
            if (wq.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_write: got addr 0x%03h data 0x%08h, want no write (cycle %0d)",
                         csr_waddr, csr_wdata, cyc);
            end else begin
                mon_w = wq.pop_front();
                chk("wr_addr", 32'(csr_waddr), 32'(mon_w.addr));
                chk("wr_data", csr_wdata, mon_w.data);
                chk("wr_wsc", 32'(csr_wsc), 32'(mon_w.wsc));
                chk("wr_cycle", 32'(cyc), 32'(mon_w.cyc));
            end
        end
        if (redirect_mux) begin
            if (rq.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_redirect: got 0x%08h, want none (cycle %0d)", PC_redirect, cyc);
            end else begin
                mon_r = rq.pop_front();
                chk("redir_pc", PC_redirect, mon_r.pc);
                chk("redir_cycle", 32'(cyc), 32'(mon_r.cyc));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ins();
        {illegal_inst, ecall_m, l_access_fault, s_access_fault, interrupt, mret, csr_rw_in} = '0;
        csr_rw_addr_in = '0;
        csr_wdata_in   = '0;
        csr_wsc_in     = '0;
    endtask

    task automatic apply_vec(input vec_t v);
        step();
        clear_ins();
        csr_rw_in      = v.rw;
        csr_rw_addr_in = v.addr;
        csr_wdata_in   = v.wdata;
        csr_wsc_in     = v.wsc;
        interrupt      = v.intr;
        if (v.exp_ready) wq.push_back('{addr: v.addr, data: v.wdata, wsc: v.wsc, cyc: cyc});
        @(negedge clk);
        chk("vec_ready", 32'(csr_rw_ready), 32'(v.exp_ready));
        chk("vec_csr_w", 32'(csr_w), 32'(v.exp_ready));
        chk("vec_flush", 32'(flush), 32'(v.exp_flush));
        if (v.exp_ready) chk("vec_raddr", 32'(csr_raddr), 32'(v.addr));
    endtask

    // ev = {illegal, ecall, l_af, s_af, interrupt, mret, csr_rw_in}
    task automatic run_trap(input string nm, input logic [6:0] ev, input logic [31:0] epc,
                            input logic [31:0] tv, input logic [31:0] cause,
                            input logic [31:0] exp_tv, input logic [31:0] status,
                            input logic [31:0] target);
        int t;
        step();
        clear_ins();
        {illegal_inst, ecall_m, l_access_fault, s_access_fault, interrupt, mret, csr_rw_in} = ev;
        epc_cur        = epc;
        tval_in        = tv;
        csr_rw_addr_in = A_MSCRATCH;
        csr_wdata_in   = 32'hAAAA_5555;
        csr_wsc_in     = 2'b01;
        t = cyc;
        wq.push_back('{addr: A_MEPC, data: epc, wsc: 2'b01, cyc: t + 1});
        wq.push_back('{addr: A_MCAUSE, data: cause, wsc: 2'b01, cyc: t + 2});
`ifdef TRAP_MTVAL_EN
        wq.push_back('{addr: A_MTVAL, data: exp_tv, wsc: 2'b01, cyc: t + 3});
`endif
        wq.push_back('{addr: A_MSTATUS, data: status, wsc: 2'b01, cyc: t + TRAP_LAT - 2});
        rq.push_back('{pc: target, cyc: t + TRAP_LAT});
        @(negedge clk);
        chk({nm, "_flush"}, 32'(flush), 32'd1);
        chk({nm, "_cancel"}, 32'(RegWrite_cancel), 32'd1);
        chk({nm, "_ready"}, 32'(csr_rw_ready), 32'd0);
        chk({nm, "_stall_t"}, 32'(stall), 32'd0);
        for (int k = 1; k <= TRAP_LAT + 1; k++) begin
            step();
            if (k == 1) clear_ins();
            @(negedge clk);
            chk({nm, "_stall"}, 32'(stall), 32'(k <= TRAP_LAT));
            chk({nm, "_redir"}, 32'(redirect_mux), 32'(k == TRAP_LAT));
        end
    endtask

    task automatic run_mret(input logic [31:0] status, input logic [31:0] target);
        int t;
        step();
        clear_ins();
        mret = 1'b1;
        t = cyc;
        wq.push_back('{addr: A_MSTATUS, data: status, wsc: 2'b01, cyc: t + 1});
        rq.push_back('{pc: target, cyc: t + 3});
        @(negedge clk);
        chk("mret_flush", 32'(flush), 32'd1);
        chk("mret_cancel", 32'(RegWrite_cancel), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            step();
            if (k == 1) clear_ins();
            @(negedge clk);
            chk("mret_stall", 32'(stall), 32'(k <= 3));
            chk("mret_redir", 32'(redirect_mux), 32'(k == 3));
        end
    endtask

    initial begin
        logic [31:0] tval_before;
        vecs[0] = '{1'b1, A_MSCRATCH, 32'hDEAD_BEEF, 2'b01, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{1'b1, A_MSCRATCH, 32'h0000_000F, 2'b10, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{1'b1, A_MSCRATCH, 32'h0000_00F0, 2'b11, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{1'b1, A_MSTATUS,  32'h0000_0008, 2'b11, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 12'h000,    32'h0,         2'b00, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{1'b1, A_MSCRATCH, 32'h1234_5678, 2'b01, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{1'b1, A_MSTATUS,  32'h0000_0008, 2'b10, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{1'b0, 12'h000,    32'h0,         2'b00, 1'b0, 1'b0, 1'b0};

        // Outputs held low in reset even with events present
        repeat (2) @(posedge clk);
        #1;
        illegal_inst = 1'b1;
        csr_rw_in    = 1'b1;
        @(negedge clk);
        chk("reset_outputs_zero", 32'(|{csr_rw_ready, csr_w, csr_waddr, csr_wdata, csr_wsc, csr_raddr,
                                        stall, flush, RegWrite_cancel, redirect_mux, PC_redirect}), 32'd0);
        step();
        clear_ins();
        rst = 1'b0;

        foreach (vecs[i]) apply_vec(vecs[i]);

        run_trap("illegal", 7'b1000000, 32'h100, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF,
                 32'h1880, 32'h200);

        // MIE is now clear: interrupt alone is ignored
        apply_vec('{1'b0, 12'h000, 32'h0, 2'b00, 1'b1, 1'b0, 1'b0});

        apply_vec('{1'b1, A_MEPC, 32'h104, 2'b01, 1'b0, 1'b1, 1'b0});
        run_mret(32'h1888, 32'h104);

        run_trap("irq", 7'b0000100, 32'h300, 32'h55, 32'h8000_000B, 32'h0, 32'h1880, 32'h200);

        // ecall + CSR instruction + mret in one cycle: trap wins, CSR write dropped
        run_trap("ecall_coll", 7'b0100011, 32'h304, 32'h77, 32'd11, 32'h0, 32'h1800, 32'h200);

        tval_before = m_mtval;
        run_trap("laf_prio", 7'b0011100, 32'h308, 32'hBAD0, 32'd5, 32'hBAD0, 32'h1800, 32'h200);
`ifdef TRAP_MTVAL_EN
        chk("laf_mtval", m_mtval, 32'hBAD0);
`else
        chk("laf_mtval_untouched", m_mtval, tval_before);
`endif
        run_trap("saf", 7'b0001000, 32'h30C, 32'hCAFE, 32'd7, 32'hCAFE, 32'h1800, 32'h200);

        // Reset while in SAVE_CAUSE
        step();
        clear_ins();
        illegal_inst = 1'b1;
        epc_cur      = 32'h400;
        tval_in      = 32'h1;
        wq.push_back('{addr: A_MEPC, data: 32'h400, wsc: 2'b01, cyc: cyc + 1});
        @(negedge clk);
        chk("midrst_flush", 32'(flush), 32'd1);
        step();
        clear_ins();
        @(negedge clk);
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_outputs_zero", 32'(|{csr_rw_ready, csr_w, csr_waddr, csr_wdata, csr_wsc, csr_raddr,
                                         stall, flush, RegWrite_cancel, redirect_mux, PC_redirect}), 32'd0);
        step();
        rst = 1'b0;
        apply_vec('{1'b1, A_MSCRATCH, 32'h0BAD_F00D, 2'b01, 1'b0, 1'b1, 1'b0});
        chk("midrst_mcause", m_mcause, 32'd7);
        chk("midrst_mepc", m_mepc, 32'h400);

        step();
        clear_ins();
        repeat (2) step();
        chk("writes_outstanding", 32'(wq.size()), 32'd0);
        chk("redirects_outstanding", 32'(rq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/trap_sequencer.md
# trap_sequencer

Multi-cycle controller that owns the single write port of the machine-mode CSR file and shares it between MEM-stage CSR instructions and trap entry/return. On a qualifying exception, interrupt or `mret` it stalls the pipeline and writes `mepc`, `mcause`, `mtval` and `mstatus` one per cycle. It then reads `mtvec` or `mepc` and issues a one-cycle PC redirect. It sits between the MEM/WB exception signals and the CSR register file, and drives the pipeline flush, stall and redirect controls.

## Interface
Parameters:
- `MTVEC_ADDR`, 12'h305, CSR address of mtvec
- `MEPC_ADDR`, 12'h341, CSR address of mepc
- `MCAUSE_ADDR`, 12'h342, CSR address of mcause
- `MTVAL_ADDR`, 12'h343, CSR address of mtval
- `MSTATUS_ADDR`, 12'h300, CSR address of mstatus

Ports:
- `clk` in 1: single clock; everything updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `csr_rw_in` in 1: MEM-stage CSR instruction request.
- `csr_rw_addr_in` in 12: CSR address for the instruction.
- `csr_wdata_in` in 32: operand (immediate or register, already selected).
- `csr_wsc_in` in 2: write mode, 01 write / 10 set / 11 clear.
- `csr_rw_ready` out 1: CSR instruction accepted this cycle.
- `illegal_inst`, `ecall_m`, `l_access_fault`, `s_access_fault`, `interrupt`, `mret` in 1 each: event inputs.
- `epc_cur` in 32: PC of the trapping instruction.
- `tval_in` in 32: faulting instruction bits or faulting address.
- `mstatus` in 32: current mstatus from the CSR file.
- `csr_rdata` in 32: CSR file read data, combinational from `csr_raddr`.
- `csr_w` out 1, `csr_waddr` out 12, `csr_wdata` out 32, `csr_wsc` out 2: CSR write port.
- `csr_raddr` out 12: CSR read address.
- `stall` out 1: freeze PC and all pipeline registers.
- `flush` out 1: flush FD/DE/EM/MW.
- `RegWrite_cancel` out 1: suppress the WB write.
- `redirect_mux` out 1: select `PC_redirect`.
- `PC_redirect` out 32: redirect target.

## Operation
- States: IDLE, SAVE_EPC, SAVE_CAUSE, SAVE_TVAL, UPD_STATUS, READ_VEC, REDIRECT, MRET_STATUS, MRET_EPC.
- Trap taken in IDLE when any exception is asserted, or when `interrupt & mstatus[3]`.
- Trap priority, highest first: illegal_inst (cause 2) > ecall_m (11) > l_access_fault (5) > s_access_fault (7) > interrupt (32'h8000000B).
- On trap entry, latch the cause, `epc_cur`, and tval. Tval is `tval_in` for illegal and access faults, 0 otherwise.
- Trap path: IDLE → SAVE_EPC → SAVE_CAUSE → SAVE_TVAL → UPD_STATUS → READ_VEC → REDIRECT → IDLE.
- Each SAVE_* state writes its latched value with `csr_wsc`=01.
- UPD_STATUS writes mstatus with MPIE←MIE, MIE←0, MPP←2'b11, all other bits preserved.
- READ_VEC drives `csr_raddr`=mtvec and registers `{csr_rdata[31:2],2'b00}` as the target.
- `mret` in IDLE with no exception: IDLE → MRET_STATUS → MRET_EPC → REDIRECT.
  - MRET_STATUS writes MIE←MPIE, MPIE←1.
  - MRET_EPC reads mepc into the target.
- REDIRECT: `redirect_mux`=1 and `PC_redirect`=target for exactly one cycle.
- CSR instructions are granted only in IDLE with no trap or mret that cycle. On grant, the instruction fields pass straight to the write port and `csr_raddr`=`csr_rw_addr_in`.
- Same-cycle collisions:
  - Exception plus CSR instruction: the trap wins and the CSR write is dropped.
  - Exception plus mret: the trap wins.
- All event inputs are ignored outside IDLE.
- Reset, including mid-sequence: state IDLE and every output 0. CSR writes in flight are abandoned.

## Timing
- Trap qualified in IDLE at cycle t:
  - `flush` and `RegWrite_cancel` high combinationally in t only.
  - `stall` high t+1..t+6.
  - Writes: mepc t+1, mcause t+2, mtval t+3, mstatus t+4.
  - Redirect at t+6, back to IDLE at t+7.
- mret at t: `flush` high at t; `stall` t+1..t+3; redirect at t+3; IDLE at t+4.
- CSR instruction grant: `csr_rw_ready` and `csr_w` high in the same cycle, with zero latency.
- `csr_w` is high at most one cycle per write.

## Configuration
- `TRAP_MTVAL_EN` defined: SAVE_TVAL exists and mtval is written.
- `TRAP_MTVAL_EN` undefined:
  - SAVE_CAUSE goes directly to UPD_STATUS and mtval is never written.
  - Trap timings from mstatus onward shift one cycle earlier: redirect at t+5, `stall` t+1..t+5.

## Test plan
- Illegal instruction: `illegal_inst`=1, `epc_cur`=0x100, `tval_in`=0xFFFFFFFF, mtvec=0x200, mstatus=0x8.
  - Writes mepc=0x100, mcause=2, mtval=0xFFFFFFFF, mstatus=0x1880.
  - Redirect to 0x200 at t+6.
- Interrupt masking:
  - `interrupt`=1 with mstatus.MIE=0 → no action.
  - With MIE=1 → mcause=0x8000000B.
- mret: mepc=0x104, mstatus=0x1880 → mstatus write gives MIE=1, MPIE=1; redirect to 0x104 at t+3.
- Collision: `ecall_m` and `csr_rw_in` (mscratch write) in the same cycle → `csr_rw_ready`=0, no mscratch write, mcause=11.
- Mid-sequence reset: assert `rst` in SAVE_CAUSE → outputs 0 immediately, state IDLE, mcause unchanged.
- Build without `TRAP_MTVAL_EN`: `l_access_fault` → mtval untouched, redirect at t+5.
